m9312_multi: RTL

- Parametrised successor to the bus boot-ROM slave. Serves a low diagnostic ROM window and a high boot window split into NSOCKETS boot-ROM sockets.
- ROM contents are loaded at run time through a load port.
- Delays SSYN by a programmable count, patches the boot-switch word from live configuration inputs, and forces a vector address onto the bus for a configurable number of MSYN cycles after power-up.
- Sits on the Unibus slave side next to the CPU, with an enable from the system configuration.

---
 rtl/m9312_multi.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/m9312_multi.sv
// m9312_multi: Unibus slave serving a low diagnostic ROM window and a high boot
// window. The ROM array is loaded at run time. The slave delays SSYN by a set
// count, patches the boot-switch word from live configuration inputs, and can
// force a vector address onto the bus for the first MSYN cycles after power-up.
module m9312_multi #(
   parameter logic [8:0]  LO_BASE       = 9'o765,
   parameter logic [8:0]  HI_BASE       = 9'o773,
   parameter int unsigned NSOCKETS      = 32'd4,
   parameter int unsigned SSYN_DLY      = 32'd16,
   parameter bit          OVERRIDE_BOOT = 1'b1,
   parameter logic [17:0] VECTOR_ADDR   = 18'o773000,
   parameter int unsigned VEC_MSYNS     = 32'd2,
   parameter int unsigned PWR_TIMEOUT   = 32'o10000,
   parameter logic [7:0]  SW_WORD       = 8'o012
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        bus_pwr_lo,
   input  logic [17:0] bus_addr,
   input  logic        bus_msyn,
   output logic [17:0] bus_addr_out,
   output logic [15:0] bus_d_out,
   output logic        bus_ssyn,
   input  logic        cfg_cons,
   input  logic [8:0]  cfg_offset,
   input  logic        ld_we,
   input  logic [8:0]  ld_addr,
   input  logic [15:0] ld_data
);

   // The high window is one 256-word array. Sockets are 256/NSOCKETS words
   // each, but they only partition the load address space, so NSOCKETS has
   // no effect beyond this legality check.
   if (!(NSOCKETS == 32'd1 || NSOCKETS == 32'd2 || NSOCKETS == 32'd4 || NSOCKETS == 32'd8) ||
       SSYN_DLY == 32'd0 || SSYN_DLY > 32'd255 ||
       VEC_MSYNS == 32'd0 || VEC_MSYNS > 32'd15 || PWR_TIMEOUT == 32'd0) begin : g_bad_param
      $error("m9312_multi: parameter out of range");
   end

   localparam int unsigned    TW    = $clog2(PWR_TIMEOUT + 32'd1);
   localparam logic [7:0]     DLY_C = 8'(SSYN_DLY);
   localparam logic [3:0]     VEC_C = 4'(VEC_MSYNS);
   localparam logic [TW-1:0]  TMO_C = TW'(PWR_TIMEOUT);

   typedef enum logic [1:0] {SS_IDLE = 2'd0, SS_DELAY = 2'd1, SS_ACK = 2'd2} ss_state_t;
   typedef enum logic       {PW_OFF = 1'b0, PW_ARMED = 1'b1} pw_state_t;

   logic [15:0]  mem_q [0:511];

   logic         sel_lo_s, sel_hi_s, sel_s, sw_hit_s, trail_s, unused_s;
   logic [8:0]   rom_idx_s;
   logic [15:0]  rom_word_s, cap_word_s;

   ss_state_t    ss_q, ss_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [15:0]  data_q, data_d;

   pw_state_t    pw_q, pw_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [3:0]   ecnt_q, ecnt_d, ecnt_inc_s;
   logic         msyn_q;

   // Boot-switch patch: console switch flips the boot-device field, offset
   // switches are ORed into the low nine bits.
   function automatic logic [15:0] patch_sw(input logic [15:0] word,
                                            input logic        cons,
                                            input logic [8:0]  offset);
      logic [15:0] res;
      res        = word;
      res[12:10] = word[12:10] ^ {3{cons}};
      res[8:0]   = word[8:0] | offset;
      return res;
   endfunction

   // Address decode, ROM read port, capture word and MSYN trailing-edge detect.
   always_comb begin
      sel_lo_s   = enable & bus_msyn & (bus_addr[17:9] == LO_BASE);
      sel_hi_s   = enable & bus_msyn & (bus_addr[17:9] == HI_BASE);
      sel_s      = sel_lo_s | sel_hi_s;
      rom_idx_s  = {sel_hi_s, bus_addr[8:1]};
      rom_word_s = mem_q[rom_idx_s];
      sw_hit_s   = sel_hi_s & (bus_addr[8:1] == SW_WORD);
      if (sw_hit_s) begin
         cap_word_s = patch_sw(rom_word_s, cfg_cons, cfg_offset);
      end else begin
         cap_word_s = rom_word_s;
      end
      trail_s    = msyn_q & ~bus_msyn;
      // Byte-select bit is irrelevant for word-wide ROM reads.
      unused_s   = bus_addr[0];
   end

   // ROM array write port; contents deliberately survive reset. A read in the
   // same cycle as a write to the same index sees the old word.
   always_ff @(posedge clk) begin
      if (ld_we) begin
         mem_q[ld_addr] <= ld_data;
      end
   end

   // State and counter registers for both FSMs plus the MSYN history flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ss_q   <= SS_IDLE;
         cnt_q  <= 8'd0;
         data_q <= 16'd0;
         pw_q   <= PW_OFF;
         tcnt_q <= '0;
         ecnt_q <= 4'd0;
         msyn_q <= 1'b0;
      end else begin
         ss_q   <= ss_d;
         cnt_q  <= cnt_d;
         data_q <= data_d;
         pw_q   <= pw_d;
         tcnt_q <= tcnt_d;
         ecnt_q <= ecnt_d;
         msyn_q <= bus_msyn;
      end
   end

   // SSYN FSM next state: capture on select, count the delay, hold ACK until
   // the master releases; a select drop during the delay aborts quietly.
   always_comb begin
      ss_d   = ss_q;
      cnt_d  = cnt_q;
      data_d = data_q;
      case (ss_q)
         SS_IDLE: begin
            if (sel_s) begin
               ss_d   = SS_DELAY;
               cnt_d  = 8'd1;
               data_d = cap_word_s;
            end else begin
               ss_d   = SS_IDLE;
            end
         end
         SS_DELAY: begin
            if (!sel_s) begin
               ss_d  = SS_IDLE;
               cnt_d = 8'd0;
            end else if (cnt_q == DLY_C) begin
               ss_d  = SS_ACK;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         SS_ACK: begin
            if (!sel_s) begin
               ss_d  = SS_IDLE;
               cnt_d = 8'd0;
            end else begin
               ss_d  = SS_ACK;
            end
         end
         default: begin
            ss_d  = SS_IDLE;
            cnt_d = 8'd0;
         end
      endcase
   end

   // Power-up FSM next state: power-low re-arms and clears the counters with
   // top priority; otherwise leave on the Nth MSYN trailing edge or timeout.
   always_comb begin
      pw_d       = pw_q;
      tcnt_d     = tcnt_q;
      ecnt_d     = ecnt_q;
      ecnt_inc_s = ecnt_q + {3'd0, trail_s};
      if (bus_pwr_lo) begin
         pw_d   = PW_ARMED;
         tcnt_d = '0;
         ecnt_d = 4'd0;
      end else begin
         case (pw_q)
            PW_ARMED: begin
               if ((ecnt_inc_s == VEC_C) || (tcnt_q == TMO_C)) begin
                  pw_d   = PW_OFF;
                  tcnt_d = '0;
                  ecnt_d = 4'd0;
               end else begin
                  pw_d   = PW_ARMED;
                  tcnt_d = tcnt_q + TW'(1);
                  ecnt_d = ecnt_inc_s;
               end
            end
            PW_OFF: begin
               pw_d = PW_OFF;
            end
            default: begin
               pw_d   = PW_OFF;
               tcnt_d = '0;
               ecnt_d = 4'd0;
            end
         endcase
      end
   end

   // Bus outputs decoded from registered state; the override is gated by
   // enable so dropping enable releases the address lines at once.
   always_comb begin
      bus_ssyn     = 1'b0;
      bus_d_out    = 16'd0;
      bus_addr_out = 18'd0;
      if (ss_q == SS_ACK) begin
         bus_ssyn  = 1'b1;
         bus_d_out = data_q;
      end else begin
         bus_ssyn  = 1'b0;
         bus_d_out = 16'd0;
      end
      if ((pw_q == PW_ARMED) && enable && OVERRIDE_BOOT) begin
         bus_addr_out = VECTOR_ADDR;
      end else begin
         bus_addr_out = 18'd0;
      end
   end

endmodule
